// File: rtl/two_to_four_demux_pkg.sv
// Shared types for the 2-to-4 pair demux: route-select encodings, lane indices
// and the route map from a select value to its two target lanes.
package two_to_four_demux_pkg;

    localparam int unsigned DEMUX_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        SE_AB = 2'b00,
        SE_BC = 2'b01,
        SE_CD = 2'b10,
        SE_AD = 2'b11
    } se_e;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

    function automatic lane_e m_lane(input se_e se);
        case (se)
            SE_AB:   return LANE_A;
            SE_BC:   return LANE_B;
            SE_CD:   return LANE_C;
            default: return LANE_A;
        endcase
    endfunction

    function automatic lane_e n_lane(input se_e se);
        case (se)
            SE_AB:   return LANE_B;
            SE_BC:   return LANE_C;
            SE_CD:   return LANE_D;
            default: return LANE_D;
        endcase
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: a single-entry holding register with a valid flag,
// drained by a downstream ack and refillable in the same cycle as the ack.
module demux_lane
    import two_to_four_demux_pkg::*;
#(
    parameter int unsigned W = DEMUX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         ack,
    output logic [W-1:0] data,
    output logic         vld,
    output logic         free
);

    logic [W-1:0] data_q, data_d;
    logic         vld_q, vld_d;

    // A write wins over an ack so a lane sustains one transfer per cycle.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (wr_en) begin
            data_d = wr_data;
            vld_d  = 1'b1;
        end else if (ack) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data = data_q;
    assign vld  = vld_q;
    assign free = !vld_q || ack;

endmodule

// File: rtl/two_to_four_demux.sv
// Scatters an input pair (M, N) into two of four holding lanes chosen by SE.
// Optional stall-cycle counter enabled by macro TWO_TO_FOUR_DEMUX_STALL_CNT_EN.
module two_to_four_demux
    import two_to_four_demux_pkg::*;
#(
    parameter int unsigned W = DEMUX_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] M,
    input  logic [W-1:0] N,
    input  logic [1:0]   SE,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    output logic [W-1:0] D,
    output logic         a_vld,
    output logic         b_vld,
    output logic         c_vld,
    output logic         d_vld,
    input  logic         a_ack,
    input  logic         b_ack,
    input  logic         c_ack,
    input  logic         d_ack
`ifdef TWO_TO_FOUR_DEMUX_STALL_CNT_EN
    ,
    output logic [7:0]   stall_cnt
`endif
);

    lane_e        m_tgt, n_tgt;
    logic [3:0]   m_sel, n_sel;
    logic [3:0]   lane_free, lane_we;
    logic         accept;
    logic [W-1:0] lane_wdata [4];

    always_comb begin
        m_tgt    = m_lane(se_e'(SE));
        n_tgt    = n_lane(se_e'(SE));
        m_sel    = 4'b0001 << m_tgt;
        n_sel    = 4'b0001 << n_tgt;
        in_ready = lane_free[m_tgt] && lane_free[n_tgt];
        accept   = in_valid && in_ready;
        lane_we  = accept ? (m_sel | n_sel) : '0;
        for (int unsigned i = 0; i < 4; i++) begin
            lane_wdata[i] = m_sel[i] ? M : N;
        end
    end

    demux_lane #(.W(W)) u_lane_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_we[LANE_A]),
        .wr_data (lane_wdata[LANE_A]),
        .ack     (a_ack),
        .data    (A),
        .vld     (a_vld),
        .free    (lane_free[LANE_A])
    );

    demux_lane #(.W(W)) u_lane_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_we[LANE_B]),
        .wr_data (lane_wdata[LANE_B]),
        .ack     (b_ack),
        .data    (B),
        .vld     (b_vld),
        .free    (lane_free[LANE_B])
    );

    demux_lane #(.W(W)) u_lane_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_we[LANE_C]),
        .wr_data (lane_wdata[LANE_C]),
        .ack     (c_ack),
        .data    (C),
        .vld     (c_vld),
        .free    (lane_free[LANE_C])
    );

    demux_lane #(.W(W)) u_lane_d (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lane_we[LANE_D]),
        .wr_data (lane_wdata[LANE_D]),
        .ack     (d_ack),
        .data    (D),
        .vld     (d_vld),
        .free    (lane_free[LANE_D])
    );

`ifdef TWO_TO_FOUR_DEMUX_STALL_CNT_EN
    logic [7:0] stall_q, stall_d;

    // Saturating count of cycles the upstream is held off.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_two_to_four_demux.sv
// Scoreboard bench for two_to_four_demux: a lane-array reference model predicts
// in_ready and the post-edge lane state; a monitor compares after every edge.
module tb_two_to_four_demux;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] M, N;
    logic [1:0]   SE;
    logic         in_valid, in_ready;
    logic [W-1:0] A, B, C, D;
    logic         a_vld, b_vld, c_vld, d_vld;
    logic         a_ack, b_ack, c_ack, d_ack;
`ifdef TWO_TO_FOUR_DEMUX_STALL_CNT_EN
    logic [7:0]   stall_cnt;
`endif

    two_to_four_demux #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .M        (M),
        .N        (N),
        .SE       (SE),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .a_vld    (a_vld),
        .b_vld    (b_vld),
        .c_vld    (c_vld),
        .d_vld    (d_vld),
        .a_ack    (a_ack),
        .b_ack    (b_ack),
        .c_ack    (c_ack),
        .d_ack    (d_ack)
`ifdef TWO_TO_FOUR_DEMUX_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Route table: target lane index (0=A..3=D) of M and of N for each SE.
    int r_m [4] = '{0, 1, 2, 0};
    int r_n [4] = '{1, 2, 3, 3};

    logic [W-1:0] md [4];
    bit   [3:0]   mv;
    bit           last_rdy;

    typedef struct packed {
        logic [3:0][W-1:0] d;
        logic [3:0]        v;
    } snap_t;

    snap_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) md[i] = '0;
        mv = '0;
        sb.delete();
    endtask

    // One clock of stimulus: drive, check in_ready, advance model, queue expectation.
    task automatic cycle(input bit iv, input logic [W-1:0] m, input logic [W-1:0] n,
                         input logic [1:0] se, input bit [3:0] ack);
        bit    fm, fn, rdy;
        snap_t s;
        @(negedge clk);
        in_valid = iv;
        M = m;
        N = n;
        SE = se;
        {d_ack, c_ack, b_ack, a_ack} = ack;
        #1;
        fm  = !mv[r_m[se]] || ack[r_m[se]];
        fn  = !mv[r_n[se]] || ack[r_n[se]];
        rdy = fm && fn;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        last_rdy = rdy;
        mv = mv & ~ack;
        if (iv && rdy) begin
            md[r_m[se]] = m;
            md[r_n[se]] = n;
            mv[r_m[se]] = 1'b1;
            mv[r_n[se]] = 1'b1;
        end
        for (int i = 0; i < 4; i++) s.d[i] = md[i];
        s.v = mv;
        sb.push_back(s);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, {16'd0, D, C, B, A}, 32'd0);
        chk({tag, "_vld"}, {28'd0, d_vld, c_vld, b_vld, a_vld}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        {d_ack, c_ack, b_ack, a_ack} = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all_zero("after_reset");
    endtask

    // Monitor: every edge the DUT presents a new lane state; compare with the queue head.
    initial begin
        snap_t        s;
        logic [W-1:0] act_d [4];
        logic [3:0]   act_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                s = sb.pop_front();
                act_d = '{A, B, C, D};
                act_v = {d_vld, c_vld, b_vld, a_vld};
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("lane%0d_data", i), {28'd0, act_d[i]}, {28'd0, s.d[i]});
                    chk($sformatf("lane%0d_vld", i), {31'd0, act_v[i]}, {31'd0, s.v[i]});
                end
            end
        end
    end

    initial begin
        logic [W-1:0] lanes [4];
        logic [W-1:0] rm, rn;
        logic [1:0]   rse;
        bit           hold;
        bit [3:0]     vmask [4];
        vmask = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};

        rst_n = 1'b0;
        in_valid = 1'b0;
        M = '0;
        N = '0;
        SE = '0;
        {d_ack, c_ack, b_ack, a_ack} = '0;
        model_clear();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: every select reports ready with all lanes empty.
        for (int se = 0; se < 4; se++) begin
            cycle(1'b0, '0, '0, 2'(se), 4'h0);
            chk("idle_ready", {31'd0, in_ready}, 32'd1);
        end

        // Routing of (3,5) through every select, draining all lanes between pairs.
        for (int se = 0; se < 4; se++) begin
            cycle(1'b1, 4'h3, 4'h5, 2'(se), 4'h0);
            cycle(1'b0, '0, '0, 2'(se), 4'hF);
            lanes = '{A, B, C, D};
            chk("route_vld", {28'd0, d_vld, c_vld, b_vld, a_vld}, {28'd0, vmask[se]});
            chk("route_m", {28'd0, lanes[r_m[se]]}, 32'h3);
            chk("route_n", {28'd0, lanes[r_n[se]]}, 32'h5);
        end
        cycle(1'b0, '0, '0, 2'b00, 4'h0);

        // Backpressure: B still full blocks SE=01 until b_ack frees it.
        cycle(1'b1, 4'h1, 4'h2, 2'b00, 4'h0);
        cycle(1'b1, 4'h7, 4'h8, 2'b01, 4'h0);
        chk("bp_stall", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 4'h7, 4'h8, 2'b01, 4'b0010);
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, '0, '0, 2'b01, 4'h0);
        chk("bp_B", {28'd0, B}, 32'h7);
        chk("bp_C", {28'd0, C}, 32'h8);
        chk("bp_A_held", {27'd0, a_vld, A}, 32'h11);

        // Same-cycle ack and rewrite of lane A.
        cycle(1'b1, 4'hC, 4'hD, 2'b11, 4'b0001);
        chk("ackwr_ready", {31'd0, in_ready}, 32'd1);
        cycle(1'b0, '0, '0, 2'b11, 4'h0);
        chk("ackwr_A", {27'd0, a_vld, A}, 32'h1C);
        chk("ackwr_D", {27'd0, d_vld, D}, 32'h1D);

        do_reset_mid();

        // Randomised traffic; a stalled pair is held stable until accepted.
        hold = 1'b0;
        rm = '0;
        rn = '0;
        rse = '0;
        for (int k = 0; k < 400; k++) begin
            bit iv;
            if (hold) begin
                iv = 1'b1;
            end else begin
                iv  = ($urandom_range(0, 3) != 0);
                rm  = W'($urandom);
                rn  = W'($urandom);
                rse = 2'($urandom);
            end
            cycle(iv, rm, rn, rse, 4'($urandom));
            hold = iv && !last_rdy;
            if (k == 200) begin
                cycle(1'b0, '0, '0, 2'b00, 4'h0);
                do_reset_mid();
                hold = 1'b0;
            end
        end
        cycle(1'b0, '0, '0, 2'b00, 4'h0);

`ifdef TWO_TO_FOUR_DEMUX_STALL_CNT_EN
        do_reset_mid();
        chk("stall_cnt_reset", {24'd0, stall_cnt}, 32'd0);
        cycle(1'b1, 4'h1, 4'h2, 2'b00, 4'h0);
        for (int k = 0; k < 300; k++) cycle(1'b1, 4'h1, 4'h2, 2'b00, 4'h0);
        cycle(1'b0, '0, '0, 2'b00, 4'h0);
        chk("stall_cnt_sat", {24'd0, stall_cnt}, 32'hFF);
        do_reset_mid();
        chk("stall_cnt_clear", {24'd0, stall_cnt}, 32'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
